// File: rtl/regfile_sb_if.sv
// Decode/issue-stage view of the register file: read ports, writeback, allocate, flush and scoreboard status.
// Parameters must match the regfile_sb instance they connect to.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [AW:0]         busy_cnt;
    logic                waw_err;

    modport master (
        output rd_addr, alloc_en, alloc_addr, wb_en, wb_addr, wb_data, flush,
        input  rd_data, rd_busy, busy_cnt, waw_err
    );

    modport slave (
        input  rd_addr, alloc_en, alloc_addr, wb_en, wb_addr, wb_data, flush,
        output rd_data, rd_busy, busy_cnt, waw_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file (x0 hardwired zero) with per-register write-pending busy bits, busy popcount and sticky WAW flag.
// Latency: reads combinational; writes/allocs visible next cycle (same cycle for writeback data when RF_BYPASS_EN is defined).
// Backpressure: none, every strobe is accepted every cycle.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int          AW     = $clog2(NREG);
    localparam int          CW     = AW + 1;
    localparam logic [AW:0] NREG_V = CW'(NREG);

    logic [XLEN-1:0] regs [1:NREG-1];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic [CW-1:0]   busy_cnt_q;
    logic            waw_q;
    logic            wb_hit;
    logic            alloc_hit;
    logic            waw_set;
    logic [AW-1:0]   ra;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREG_V);
    endfunction

    assign wb_hit    = bus.wb_en && addr_ok(bus.wb_addr);
    assign alloc_hit = bus.alloc_en && addr_ok(bus.alloc_addr);

    // A writeback to the same register in the same cycle retires the older
    // producer, so re-allocating it is not a WAW hazard.
    assign waw_set = alloc_hit && busy[bus.alloc_addr]
                     && !(wb_hit && (bus.wb_addr == bus.alloc_addr));

    always_comb begin
        busy_nxt = busy;
        if (wb_hit)
            busy_nxt[bus.wb_addr] = 1'b0;
        if (alloc_hit)
            busy_nxt[bus.alloc_addr] = 1'b1;
        if (bus.flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 1; i < NREG; i++)
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_hit) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_cnt_q <= '0;
            waw_q      <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            busy_cnt_q <= cnt_nxt;
            waw_q      <= waw_q | waw_set;
        end
    end

    assign bus.busy_cnt = busy_cnt_q;
    assign bus.waw_err  = waw_q;

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra          = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.rd_addr[k*AW +: AW];
            if (addr_ok(ra)) begin
                bus.rd_data[k*XLEN +: XLEN] = regs[ra];
                bus.rd_busy[k]              = busy[ra];
`ifdef RF_BYPASS_EN
                if (wb_hit && (ra == bus.wb_addr)) begin
                    bus.rd_data[k*XLEN +: XLEN] = bus.wb_data;
                    bus.rd_busy[k]              = alloc_hit && (bus.alloc_addr == ra);
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expected outputs tagged with a cycle number, a negedge monitor compares them.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 24;
    localparam int NRD  = 3;
    localparam int AW   = $clog2(NREG);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // kind: 0 rd_data, 1 rd_busy, 2 busy_cnt, 3 waw_err
    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] act;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                0:       act = bus.rd_data[e.port*XLEN +: XLEN];
                1:       act = 32'(bus.rd_busy[e.port]);
                2:       act = 32'(bus.busy_cnt);
                default: act = 32'(bus.waw_err);
            endcase
            n_vec++;
            if (e.cyc != cyc || act !== e.val) begin
                n_bad++;
                $display("FAIL kind%0d port%0d cyc%0d (now %0d): got %h want %h",
                         e.kind, e.port, e.cyc, cyc, act, e.val);
            end
        end
    end

    task automatic push(input int kind, input int port, input logic [31:0] val);
        exp_t x;
        x.cyc = cyc; x.kind = kind; x.port = port; x.val = val;
        sb.push_back(x);
    endtask

    task automatic exp_rd(input int port, input logic [31:0] d, input logic b);
        push(0, port, d);
        push(1, port, 32'(b));
    endtask

    task automatic exp_st(input int cnt, input logic waw);
        push(2, 0, 32'(cnt));
        push(3, 0, 32'(waw));
    endtask

    task automatic rd(input int a0, input int a1, input int a2);
        bus.rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic drv(input logic ae, input int aa, input logic we, input int wa,
                       input logic [31:0] wd, input logic fl);
        bus.alloc_en = ae; bus.alloc_addr = AW'(aa);
        bus.wb_en = we; bus.wb_addr = AW'(wa); bus.wb_data = wd;
        bus.flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drv(1'b0, 0, 1'b0, 0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rd(0, 0, 0);
        drv(1'b0, 0, 1'b0, 0, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state over all addresses, including out-of-range ones
        for (int a = 0; a < 32; a += 3) begin
            rd(a, a + 1, a + 2);
            for (int p = 0; p < NRD; p++) exp_rd(p, 32'h0, 1'b0);
            exp_st(0, 1'b0);
            tick();
        end

        // Alloc x5, writeback three cycles later
        rd(5, 0, 5);
        drv(1'b1, 5, 1'b0, 0, 32'h0, 1'b0);
        exp_rd(0, 32'h0, 1'b0); exp_st(0, 1'b0);
        tick();
        exp_rd(0, 32'h0, 1'b1); exp_st(1, 1'b0);
        tick();
        exp_rd(0, 32'h0, 1'b1); exp_st(1, 1'b0);
        tick();
        drv(1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0);
`ifdef RF_BYPASS_EN
        exp_rd(0, 32'hDEADBEEF, 1'b0);
`else
        exp_rd(0, 32'h0, 1'b1);
`endif
        exp_st(1, 1'b0);
        tick();
        exp_rd(0, 32'hDEADBEEF, 1'b0); exp_rd(2, 32'hDEADBEEF, 1'b0); exp_st(0, 1'b0);
        tick();

        // x0 protection
        rd(0, 5, 0);
        drv(1'b1, 0, 1'b1, 0, 32'hFFFFFFFF, 1'b0);
        exp_rd(0, 32'h0, 1'b0);
        tick();
        exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'hDEADBEEF, 1'b0); exp_st(0, 1'b0);
        tick();

        // Same-cycle alloc + writeback on x7, then a second alloc (WAW)
        rd(7, 0, 0);
        drv(1'b1, 7, 1'b1, 7, 32'h12, 1'b0);
`ifdef RF_BYPASS_EN
        exp_rd(0, 32'h12, 1'b1);
`else
        exp_rd(0, 32'h0, 1'b0);
`endif
        tick();
        exp_rd(0, 32'h12, 1'b1); exp_st(1, 1'b0);
        drv(1'b1, 7, 1'b0, 0, 32'h0, 1'b0);
        tick();
        exp_rd(0, 32'h12, 1'b1); exp_st(1, 1'b1);
        tick();
        exp_st(1, 1'b1);
        drv(1'b0, 0, 1'b1, 7, 32'h34, 1'b0);
        tick();
        exp_rd(0, 32'h34, 1'b0); exp_st(0, 1'b1);
        drv(1'b0, 0, 1'b1, 1, 32'h111, 1'b0);
        tick();
        drv(1'b0, 0, 1'b1, 2, 32'h222, 1'b0);
        tick();

        // Flush with concurrent alloc and writeback
        rd(1, 2, 3);
        drv(1'b1, 1, 1'b0, 0, 32'h0, 1'b0); tick();
        drv(1'b1, 2, 1'b0, 0, 32'h0, 1'b0); tick();
        drv(1'b1, 3, 1'b0, 0, 32'h0, 1'b0); tick();
        exp_rd(0, 32'h111, 1'b1); exp_rd(1, 32'h222, 1'b1); exp_rd(2, 32'h0, 1'b1);
        exp_st(3, 1'b1);
        drv(1'b1, 4, 1'b1, 9, 32'h55, 1'b1);
        tick();
        rd(1, 4, 9);
        exp_rd(0, 32'h111, 1'b0); exp_rd(1, 32'h0, 1'b0); exp_rd(2, 32'h55, 1'b0);
        exp_st(0, 1'b1);
        tick();

        // Multi-port independent reads
        rd(1, 2, 1);
        exp_rd(0, 32'h111, 1'b0); exp_rd(1, 32'h222, 1'b0); exp_rd(2, 32'h111, 1'b0);
        tick();

        // Out-of-range writeback/alloc is ignored
        rd(30, 23, 0);
        drv(1'b1, 30, 1'b1, 30, 32'hAA, 1'b0);
        exp_rd(0, 32'h0, 1'b0);
        tick();
        exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'h0, 1'b0); exp_st(0, 1'b1);
        tick();

        // Reset mid-operation with four busy registers
        rd(1, 2, 9);
        for (int r = 1; r <= 4; r++) begin
            drv(1'b1, r, 1'b0, 0, 32'h0, 1'b0);
            tick();
        end
        exp_st(4, 1'b1); exp_rd(0, 32'h111, 1'b1);
        rst = 1'b1;
        drv(1'b1, 5, 1'b1, 6, 32'h66, 1'b0);
        tick();
        rst = 1'b0;
        exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'h0, 1'b0); exp_rd(2, 32'h0, 1'b0);
        exp_st(0, 1'b0);
        tick();
        tick();

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
